core_bus_arbiter: RTL



---
 rtl/core_bus_arbiter_pkg.sv | 65 ++++++
 rtl/core_bus_arbiter.sv | 99 +++++++++
 2 files changed

// File: rtl/core_bus_arbiter_pkg.sv
// Shared bus types for the core-side ibus/dbus and the single-beat cache bus.
// The arbiter and its neighbours import these so field layouts stay in one place.
package core_bus_arbiter_pkg;

    typedef logic [63:0] addr_t;
    typedef logic [63:0] word_t;
    typedef logic [7:0]  strobe_t;
    typedef logic [3:0]  mlen_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    localparam mlen_t MLEN1 = 4'd0;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef struct packed {
        logic    valid;
        logic    is_write;
        msize_t  size;
        addr_t   addr;
        strobe_t strobe;
        word_t   data;
        mlen_t   len;
    } cbus_req_t;

    typedef struct packed {
        logic  ready;
        logic  last;
        word_t data;
    } cbus_resp_t;

    // Instruction words sit in 64-bit beats; addr[2] picks the upper half.
    function automatic logic [31:0] pick_word(input addr_t addr, input word_t beat);
        return addr[2] ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/core_bus_arbiter.sv
// Merges the core's fetch and load/store buses onto one single-beat cache bus.
// Data side has priority, but fetch wins right after a data transaction.
module core_bus_arbiter
    import core_bus_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state;
    logic        sel_d;
    logic        last_was_d;
    cbus_req_t   cmd;
    logic        i_ok;
    logic        d_ok;
    logic [31:0] i_data;
    word_t       d_data;

    logic grant_d;
    logic grant_i;
    logic idle;

    assign idle    = (state == S_IDLE) && !reset;
    assign grant_d = dreq.valid && !(last_was_d && ireq.valid);
    assign grant_i = ireq.valid && !grant_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            sel_d      <= 1'b0;
            last_was_d <= 1'b0;
            cmd        <= '0;
            i_ok       <= 1'b0;
            d_ok       <= 1'b0;
            i_data     <= '0;
            d_data     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_d || grant_i) begin
                        sel_d        <= grant_d;
                        cmd.valid    <= 1'b1;
                        cmd.is_write <= grant_d && (dreq.strobe != '0);
                        cmd.size     <= grant_d ? dreq.size : MSIZE4;
                        cmd.addr     <= grant_d ? dreq.addr : ireq.addr;
                        cmd.strobe   <= grant_d ? dreq.strobe : '0;
                        cmd.data     <= grant_d ? dreq.data : '0;
                        cmd.len      <= MLEN1;
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A ready without last cannot complete a single-beat command.
                    if (cresp.ready && cresp.last) begin
                        cmd    <= '0;
                        i_ok   <= !sel_d;
                        d_ok   <= sel_d;
                        i_data <= sel_d ? 32'd0 : pick_word(cmd.addr, cresp.data);
                        d_data <= sel_d ? cresp.data : '0;
                        state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    i_ok       <= 1'b0;
                    d_ok       <= 1'b0;
                    i_data     <= '0;
                    d_data     <= '0;
                    last_was_d <= sel_d;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        iresp         = '0;
        dresp         = '0;
        iresp.addr_ok = idle && grant_i;
        iresp.data_ok = i_ok;
        iresp.data    = i_data;
        dresp.addr_ok = idle && grant_d;
        dresp.data_ok = d_ok;
        dresp.data    = d_data;
    end

    assign creq = cmd;

endmodule
